l1_mmu_arbiter: RTL

Two-requester arbiter that shares the single MMU line port between the L1 instruction cache and the L1 data cache. It accepts level-held read/write requests from both caches and grants one at a time, with round-robin tie-breaking. While a request is granted, it holds the MMU address, data and command stable, then routes the MMU completion back to the granted cache only. A watchdog flags transactions that never complete.

---
 rtl/l1_mmu_arbiter_if.sv | 48 ++++
 rtl/l1_mmu_arbiter.sv | 108 ++++++++++
 2 files changed

// File: rtl/l1_mmu_arbiter_if.sv
// Bundle of signals shared by the I-cache, the D-cache, the MMU line port and
// l1_mmu_arbiter.
//   slave  : the arbiter's view. It takes cache requests and the MMU response,
//            and drives the cache completions, the MMU command and timeout_err.
//   master : the environment's view, which is the opposite direction of every
//            signal.
interface l1_mmu_arbiter_if;
  logic         ic_req_read;
  logic [31:0]  ic_req_addr;
  logic         ic_done;
  logic [255:0] ic_read_data;

  logic         dc_req_read;
  logic         dc_req_write;
  logic [31:0]  dc_req_addr;
  logic [255:0] dc_write_data;
  logic         dc_done;
  logic [255:0] dc_read_data;

  logic         mmu_req_read;
  logic         mmu_req_write;
  logic [31:0]  mmu_req_addr;
  logic [255:0] mmu_write_data;
  logic         mmu_done;
  logic [255:0] mmu_read_data;

  logic         timeout_err;

  modport slave (
    input  ic_req_read, ic_req_addr,
    input  dc_req_read, dc_req_write, dc_req_addr, dc_write_data,
    input  mmu_done, mmu_read_data,
    output ic_done, ic_read_data,
    output dc_done, dc_read_data,
    output mmu_req_read, mmu_req_write, mmu_req_addr, mmu_write_data,
    output timeout_err
  );

  modport master (
    output ic_req_read, ic_req_addr,
    output dc_req_read, dc_req_write, dc_req_addr, dc_write_data,
    output mmu_done, mmu_read_data,
    input  ic_done, ic_read_data,
    input  dc_done, dc_read_data,
    input  mmu_req_read, mmu_req_write, mmu_req_addr, mmu_write_data,
    input  timeout_err
  );
endinterface

// File: rtl/l1_mmu_arbiter.sv
// Shares the single MMU line port between the L1 I-cache and the L1 D-cache.
// It grants one requester at a time and breaks ties round-robin. While a
// grant is active it holds the MMU command stable, and it sends mmu_done back
// only to the granted cache. A watchdog sets a sticky flag when a grant waits
// too long for completion.
// Ports:
//   sys_clk : clock. All state changes on its rising edge.
//   rst     : synchronous, active-high reset.
//   bus     : cache request/completion signals, the MMU command/response and
//             timeout_err. This is the slave modport of l1_mmu_arbiter_if.
// Parameter:
//   TIMEOUT : number of grant cycles without mmu_done before timeout_err sets.
module l1_mmu_arbiter #(
  parameter int unsigned TIMEOUT = 1023
) (
  input  logic             sys_clk,
  input  logic             rst,
  l1_mmu_arbiter_if.slave  bus
);

  localparam int unsigned CW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {IDLE, GNT_I, GNT_D, REL} state_t;

  state_t         state;
  logic           last_gnt_d;   // 1: the most recent grant went to the D-cache
  logic           req_rd_q;
  logic           req_wr_q;
  logic [31:0]    addr_q;
  logic [255:0]   wdata_q;
  logic [CW-1:0]  wd_cnt;
  logic           err_q;

  logic req_i;
  logic req_d;

  assign req_i = bus.ic_req_read;
  assign req_d = bus.dc_req_read | bus.dc_req_write;

  always_ff @(posedge sys_clk) begin
    if (rst) begin
      state      <= IDLE;
      last_gnt_d <= 1'b0;
      req_rd_q   <= 1'b0;
      req_wr_q   <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      wd_cnt     <= '0;
      err_q      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          // On a tie, the I-cache wins only when the D-cache had the last grant.
          if (req_i && (!req_d || last_gnt_d)) begin
            state      <= GNT_I;
            addr_q     <= bus.ic_req_addr;
            req_rd_q   <= 1'b1;
            req_wr_q   <= 1'b0;
            last_gnt_d <= 1'b0;
            wd_cnt     <= '0;
          end else if (req_d) begin
            state      <= GNT_D;
            addr_q     <= bus.dc_req_addr;
            last_gnt_d <= 1'b1;
            wd_cnt     <= '0;
            // When the D-cache asks for both, the write-back goes first and
            // the read stays pending for a later grant.
            if (bus.dc_req_write) begin
              wdata_q  <= bus.dc_write_data;
              req_rd_q <= 1'b0;
              req_wr_q <= 1'b1;
            end else begin
              req_rd_q <= 1'b1;
              req_wr_q <= 1'b0;
            end
          end
        end
        GNT_I, GNT_D: begin
          if (bus.mmu_done) begin
            state    <= REL;
            req_rd_q <= 1'b0;
            req_wr_q <= 1'b0;
          end else begin
            // The count stops at TIMEOUT so it cannot wrap. The flag is set on
            // the same edge at which the count reaches TIMEOUT.
            if (wd_cnt != CW'(TIMEOUT))
              wd_cnt <= wd_cnt + 1'b1;
            if (wd_cnt == CW'(TIMEOUT - 1))
              err_q <= 1'b1;
          end
        end
        REL: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.ic_done        = bus.mmu_done & (state == GNT_I);
  assign bus.dc_done        = bus.mmu_done & (state == GNT_D);
  assign bus.ic_read_data   = bus.mmu_read_data;
  assign bus.dc_read_data   = bus.mmu_read_data;
  assign bus.mmu_req_read   = req_rd_q;
  assign bus.mmu_req_write  = req_wr_q;
  assign bus.mmu_req_addr   = addr_q;
  assign bus.mmu_write_data = wdata_q;
  assign bus.timeout_err    = err_q;

endmodule
